// File: rtl/lu_cmp_sched.sv
// lu_cmp_sched
//
// Shares a single W-bit per-bit logic unit between two requesters. The unit
// computes XNOR when op=0 (equality) and XOR when op=1 (difference). The
// controller arbitrates, latches the winner's op/operands, and runs a fixed
// IDLE -> EXEC -> DONE cycle. It returns the per-bit result and a reduced
// compare flag to the winner.
//
// Configuration macro:
//   LU_CMP_SCHED_RR_EN  defined    : round-robin tie-break, so the requester
//                                    that did not win last time wins a tie.
//                       undefined  : fixed priority, requester 0 wins a tie.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   req0/req1  in   request from requester 0 / 1
//   op0/op1    in   operation select: 0 = equality (XNOR), 1 = difference (XOR)
//   a0,b0      in   W-bit operands of requester 0
//   a1,b1      in   W-bit operands of requester 1
//   gnt        out  one-hot grant, one-cycle pulse
//   busy       out  high while an operation is in flight (EXEC, DONE)
//   done       out  one-cycle pulse: result/flag valid
//   done_id    out  requester that owns the current result
//   result     out  registered per-bit result
//   flag       out  op=0: AND of result bits (a==b); op=1: OR (a!=b)
//
// All outputs are registered, so no combinational path exists from any input
// to any output.

module lu_cmp_sched #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic         op0,
  input  logic         op1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] result,
  output logic         flag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Per-bit logic unit: XNOR for equality, XOR for difference.
  function automatic logic [W-1:0] lu_eval(input logic op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
    return op ? x : ~x;
  endfunction

  // Reduction over all W result bits. Every bit must match for equality, and
  // any differing bit signals a difference.
  function automatic logic lu_reduce(input logic op, input logic [W-1:0] r);
    return op ? (|r) : (&r);
  endfunction

  state_t       r_state, w_state_nxt;
  logic [1:0]   r_gnt, w_gnt_nxt;
  logic         r_busy, w_busy_nxt;
  logic         r_done, w_done_nxt;
  logic         r_done_id, w_done_id_nxt;
  logic [W-1:0] r_result, w_result_nxt;
  logic         r_flag, w_flag_nxt;
  logic         r_last_id, w_last_id_nxt;
  logic         r_op, w_op_nxt;
  logic [W-1:0] r_a, w_a_nxt;
  logic [W-1:0] r_b, w_b_nxt;

  logic         w_win;
  logic [W-1:0] w_lu;

  // Winner selection. The value is used only when at least one req is high.
  always_comb begin
    w_win = 1'b0;
    if (req1 && !req0) begin
      w_win = 1'b1;
    end else if (req0 && req1) begin
`ifdef LU_CMP_SCHED_RR_EN
      w_win = ~r_last_id;
`else
      w_win = 1'b0;
`endif
    end
  end

  // The shared unit sees only the latched operands.
  assign w_lu = lu_eval(r_op, r_a, r_b);

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = 2'b00;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_done_id_nxt = r_done_id;
    w_result_nxt  = r_result;
    w_flag_nxt    = r_flag;
    w_last_id_nxt = r_last_id;
    w_op_nxt      = r_op;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    unique case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (req0 || req1) begin
          w_op_nxt      = w_win ? op1 : op0;
          w_a_nxt       = w_win ? a1 : a0;
          w_b_nxt       = w_win ? b1 : b0;
          w_gnt_nxt     = w_win ? 2'b10 : 2'b01;
          w_last_id_nxt = w_win;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_EXEC;
        end
      end
      S_EXEC: begin
        // last_id still names the requester granted on the previous edge.
        w_result_nxt  = w_lu;
        w_flag_nxt    = lu_reduce(r_op, w_lu);
        w_done_id_nxt = r_last_id;
        w_done_nxt    = 1'b1;
        w_busy_nxt    = 1'b1;
        w_state_nxt   = S_DONE;
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gnt     <= 2'b00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_result  <= '0;
      r_flag    <= 1'b0;
      r_last_id <= 1'b1;
      r_op      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_done_id <= w_done_id_nxt;
      r_result  <= w_result_nxt;
      r_flag    <= w_flag_nxt;
      r_last_id <= w_last_id_nxt;
      r_op      <= w_op_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign result  = r_result;
  assign flag    = r_flag;

endmodule

// File: tb/tb_lu_cmp_sched.sv
module tb_lu_cmp_sched;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1, op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         busy, done, done_id, flag;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  lu_cmp_sched #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .flag(flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         id;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_result;
    logic         exp_flag;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [1:0] exp_g;
  logic [W-1:0] prev_res;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'b0001, 4'b0001, 4'b1111, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 4'b0010, 4'b0011, 4'b0001, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 4'b0011, 4'b0011, 4'b0000, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 4'b1010, 4'b1000, 4'b1101, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 4'b1010, 4'b1000, 4'b0010, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1111, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 4'b0110, 4'b0110, 4'b1111, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0};

    idle_inputs();
    do_reset();
    chk("reset_gnt", gnt, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_done_id", done_id, 1'b0);
    chk("reset_result", result, 0);
    chk("reset_flag", flag, 1'b0);

    // Single-requester vectors.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vecs[i].id) begin
        req1 = 1'b1; op1 = vecs[i].op; a1 = vecs[i].a; b1 = vecs[i].b;
      end else begin
        req0 = 1'b1; op0 = vecs[i].op; a0 = vecs[i].a; b0 = vecs[i].b;
      end
      tick();
      chk($sformatf("v%0d_gnt", i), gnt, vecs[i].id ? 2'b10 : 2'b01);
      chk($sformatf("v%0d_busy_grant", i), busy, 1'b1);
      chk($sformatf("v%0d_done_early", i), done, 1'b0);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      chk($sformatf("v%0d_gnt_clr", i), gnt, 2'b00);
      chk($sformatf("v%0d_done", i), done, 1'b1);
      chk($sformatf("v%0d_done_id", i), done_id, vecs[i].id);
      chk($sformatf("v%0d_result", i), result, vecs[i].exp_result);
      chk($sformatf("v%0d_flag", i), flag, vecs[i].exp_flag);
      tick();
      chk($sformatf("v%0d_done_clr", i), done, 1'b0);
      chk($sformatf("v%0d_busy_clr", i), busy, 1'b0);
      chk($sformatf("v%0d_result_hold", i), result, vecs[i].exp_result);
    end

    // req1 raised while requester 0 is busy: granted at the first IDLE edge.
    @(negedge clk);
    req0 = 1'b1; op0 = 1'b0; a0 = 4'b0101; b0 = 4'b0101;
    tick();
    chk("busy_q_gnt0", gnt, 2'b01);
    req0 = 1'b0;
    req1 = 1'b1; op1 = 1'b1; a1 = 4'b1100; b1 = 4'b1010;
    tick();
    chk("busy_q_done0", done, 1'b1);
    chk("busy_q_res0", result, 4'b1111);
    chk("busy_q_gnt_mid", gnt, 2'b00);
    tick();
    chk("busy_q_gnt_k2", gnt, 2'b00);
    chk("busy_q_res_hold", result, 4'b1111);
    tick();
    chk("busy_q_gnt1", gnt, 2'b10);
    chk("busy_q_res_hold2", result, 4'b1111);
    req1 = 1'b0;
    tick();
    chk("busy_q_done1", done, 1'b1);
    chk("busy_q_id1", done_id, 1'b1);
    chk("busy_q_res1", result, 4'b0110);
    chk("busy_q_flag1", flag, 1'b1);
    tick();

    // Continuous tie after reset: first tie goes to requester 0.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; op0 = 1'b0; a0 = 4'b0011; b0 = 4'b0011;
    req1 = 1'b1; op1 = 1'b1; a1 = 4'b0011; b1 = 4'b0001;
    for (int g = 0; g < 4; g++) begin
`ifdef LU_CMP_SCHED_RR_EN
      exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      tick();
      chk($sformatf("tie%0d_gnt", g), gnt, exp_g);
      tick();
      chk($sformatf("tie%0d_done", g), done, 1'b1);
      chk($sformatf("tie%0d_id", g), done_id, exp_g[1]);
      chk($sformatf("tie%0d_result", g), result, exp_g[1] ? 4'b0010 : 4'b1111);
      tick();
      chk($sformatf("tie%0d_gap", g), gnt, 2'b00);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Reset in EXEC drops the operation.
    @(negedge clk);
    req0 = 1'b1; op0 = 1'b1; a0 = 4'b1001; b0 = 4'b0000;
    tick();
    chk("rst_mid_gnt", gnt, 2'b01);
    prev_res = result;
    chk("rst_mid_prev_nonzero", (prev_res != 0), 1'b1);
    req0 = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_gnt_clr", gnt, 2'b00);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_flag", flag, 1'b0);
    tick();
    chk("rst_mid_done2", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    req0 = 1'b1; op0 = 1'b0; a0 = 4'b1010; b0 = 4'b1000;
    req1 = 1'b1; op1 = 1'b1; a1 = 4'b1010; b1 = 4'b1000;
    tick();
    chk("rst_tie_gnt", gnt, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("rst_tie_id", done_id, 1'b0);
    chk("rst_tie_result", result, 4'b1101);
    chk("rst_tie_flag", flag, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
